// File: rtl/field_stream_reader.sv
// rtl/field_stream_reader.sv - field-vector RAM with a raster-order valid/ready reader
module field_stream_reader #(
  parameter int FIELD_WIDTH  = 8,
  parameter int FIELD_HEIGHT = 6,
  parameter int FIELD_SIZE   = FIELD_WIDTH * FIELD_HEIGHT,
  parameter int FIELD_DATAW  = 96,
  parameter int FIELD_ADDRW  = $clog2(FIELD_SIZE),
  parameter int COLW         = $clog2(FIELD_WIDTH),
  parameter int ROWW         = $clog2(FIELD_HEIGHT)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   field_we,
  input  logic [FIELD_ADDRW-1:0] field_addr_write,
  input  logic [FIELD_DATAW-1:0] field_data_in,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [FIELD_ADDRW-1:0] out_addr,
  output logic [COLW-1:0]        out_col,
  output logic [ROWW-1:0]        out_row,
  output logic [31:0]            out_xn,
  output logic [31:0]            out_yn,
  output logic [31:0]            out_mag
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2
  } state_t;

  localparam logic [FIELD_ADDRW:0]   SIZE_EXT  = (FIELD_ADDRW+1)'(FIELD_SIZE);
  localparam logic [FIELD_ADDRW-1:0] ADDR_LAST = FIELD_ADDRW'(FIELD_SIZE - 1);
  localparam logic [COLW-1:0]        COL_LAST  = COLW'(FIELD_WIDTH - 1);

  logic [FIELD_DATAW-1:0] mem [FIELD_SIZE];

  state_t                 state_q, state_d;
  logic [FIELD_ADDRW-1:0] addr_q, addr_d;
  logic [COLW-1:0]        col_q, col_d;
  logic [ROWW-1:0]        row_q, row_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   valid_q, valid_d;
  logic [FIELD_DATAW-1:0] data_q;
  logic                   load;
  logic                   wr_ok;

  // Out-of-range write addresses are silently dropped.
  assign wr_ok = field_we && ({1'b0, field_addr_write} < SIZE_EXT);

  // Field RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[field_addr_write] <= field_data_in;
    end
  end

  // Synchronous read port doubles as the output data register; a same-cycle
  // write to the fetched cell returns the old contents (read-first).
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else if (load) begin
      data_q <= mem[addr_q];
    end
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      col_q   <= col_d;
      row_q   <= row_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
    end
  end

  // Scan sequencing: fetch one cell, present it, advance on handshake.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    col_d   = col_q;
    row_d   = row_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    valid_d = valid_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d  = '0;
          col_d   = '0;
          row_d   = '0;
          busy_d  = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: begin
        load    = 1'b1;
        valid_d = 1'b1;
        state_d = VALID;
      end
      VALID: begin
        if (out_ready) begin
          valid_d = 1'b0;
          if (addr_q == ADDR_LAST) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            addr_d = addr_q + 1'b1;
            if (col_q == COL_LAST) begin
              col_d = '0;
              row_d = row_q + 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
            state_d = FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = valid_q;
  assign out_addr  = addr_q;
  assign out_col   = col_q;
  assign out_row   = row_q;
  assign out_xn    = data_q[95:64];
  assign out_yn    = data_q[63:32];
  assign out_mag   = data_q[31:0];

endmodule

// File: tb/tb_field_stream_reader.sv
// tb/tb_field_stream_reader.sv - scoreboard bench for field_stream_reader
module tb_field_stream_reader;

  localparam int W = 8;
  localparam int N = 48;

  logic        clk = 1'b0;
  logic        rst;
  logic        field_we;
  logic [5:0]  field_addr_write;
  logic [95:0] field_data_in;
  logic        start;
  logic        busy;
  logic        done;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_addr;
  logic [2:0]  out_col;
  logic [2:0]  out_row;
  logic [31:0] out_xn;
  logic [31:0] out_yn;
  logic [31:0] out_mag;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [5:0]  addr;
    logic [95:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [95:0] model [N];

  always #5 clk = ~clk;

  field_stream_reader dut (
    .clk              (clk),
    .rst              (rst),
    .field_we         (field_we),
    .field_addr_write (field_addr_write),
    .field_data_in    (field_data_in),
    .start            (start),
    .busy             (busy),
    .done             (done),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_addr         (out_addr),
    .out_col          (out_col),
    .out_row          (out_row),
    .out_xn           (out_xn),
    .out_yn           (out_yn),
    .out_mag          (out_mag)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [5:0] a, input logic [95:0] d);
    field_we         = 1'b1;
    field_addr_write = a;
    field_data_in    = d;
    tick();
    field_we = 1'b0;
    if (a < N) model[a] = d;
  endtask

  task automatic chk_entry(input string tag, input exp_t e);
    chk({tag, "_valid"}, 96'(out_valid), 96'd1);
    chk({tag, "_addr"},  96'(out_addr),  96'(e.addr));
    chk({tag, "_col"},   96'(out_col),   96'(e.addr % W));
    chk({tag, "_row"},   96'(out_row),   96'(e.addr / W));
    chk({tag, "_xn"},    96'(out_xn),    96'(e.data[95:64]));
    chk({tag, "_yn"},    96'(out_yn),    96'(e.data[63:32]));
    chk({tag, "_mag"},   96'(out_mag),   96'(e.data[31:0]));
  endtask

  // One scan: snapshot expected entries at start, pop them on presentation.
  task automatic scan(input int stall_at, input int stall_n, input int collide_at,
                      input int restart_at, input int abort_at, input int exp_done_t);
    int   k       = 0;
    int   t       = 0;
    int   hs_prev = 1;
    bit   early   = 1'b0;
    exp_t e;
    for (int a = 0; a < N; a++) begin
      e.addr = 6'(a);
      e.data = model[a];
      exp_q.push_back(e);
    end
    start     = 1'b1;
    out_ready = 1'b1;
    tick();
    t     = 1;
    start = 1'b0;
    while (k < N && t < 600) begin
      if (done) early = 1'b1;
      if (out_valid) begin
        e = exp_q.pop_front();
        chk_entry("entry", e);
        chk("entry_latency", 96'(t), 96'(hs_prev + 1));
        if (k == restart_at) start = 1'b1;
        if (k == abort_at) begin
          rst = 1'b1;
          tick();
          rst   = 1'b0;
          start = 1'b0;
          chk("abort_valid", 96'(out_valid), 96'd0);
          chk("abort_busy",  96'(busy),      96'd0);
          chk("abort_done",  96'(done),      96'd0);
          repeat (4) begin
            tick();
            chk("abort_no_done", 96'(done), 96'd0);
            chk("abort_idle",    96'(busy), 96'd0);
          end
          exp_q.delete();
          return;
        end
        if (k == stall_at) begin
          out_ready = 1'b0;
          repeat (stall_n) begin
            tick();
            t++;
            chk_entry("stall", e);
          end
          out_ready = 1'b1;
        end
        tick();
        t++;
        hs_prev = t;
        k++;
      end else begin
        if (k == collide_at) begin
          field_we         = 1'b1;
          field_addr_write = 6'(k);
          field_data_in    = {model[k][95:32], 32'h0007_0000};
        end
        tick();
        t++;
        start = 1'b0;
        if (field_we) begin
          field_we = 1'b0;
          model[field_addr_write] = field_data_in;
        end
      end
    end
    chk("entries_seen", 96'(k), 96'(N));
    chk("done_pulse",   96'(done),      96'd1);
    chk("done_busy",    96'(busy),      96'd0);
    chk("done_valid",   96'(out_valid), 96'd0);
    if (exp_done_t > 0) chk("done_edge", 96'(hs_prev), 96'(exp_done_t));
    chk("no_early_done", 96'(early), 96'd0);
    tick();
    chk("done_single", 96'(done), 96'd0);
    chk("idle_busy",   96'(busy), 96'd0);
  endtask

  initial begin
    rst              = 1'b1;
    field_we         = 1'b0;
    field_addr_write = '0;
    field_data_in    = '0;
    start            = 1'b0;
    out_ready        = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (20) tick();
    chk("rst_busy",  96'(busy),      96'd0);
    chk("rst_done",  96'(done),      96'd0);
    chk("rst_valid", 96'(out_valid), 96'd0);
    chk("rst_addr",  96'(out_addr),  96'd0);
    chk("rst_col",   96'(out_col),   96'd0);
    chk("rst_row",   96'(out_row),   96'd0);
    chk("rst_xn",    96'(out_xn),    96'd0);
    chk("rst_yn",    96'(out_yn),    96'd0);
    chk("rst_mag",   96'(out_mag),   96'd0);

    for (int a = 0; a < N; a++) begin
      wr(6'(a), {32'hFFFF_0000 - 32'(a), 32'(a * 3), 32'(a) << 16});
    end
    wr(6'd0, {32'd46341, 32'd46341, 32'd3276800});

    scan(-1, 0, -1, -1, -1, 97);
    scan(5, 10, 3, 10, -1, 107);
    wr(6'd48, {96{1'b1}});
    scan(-1, 0, -1, -1, -1, 97);
    scan(-1, 0, -1, -1, 20, 0);
    scan(-1, 0, -1, -1, -1, 97);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
